mssd_frame_tx: RTL and testbench

- Serial frame transmitter driving the single-wire line consumed by the MSSD receive stage.
- Accepts a frame request (2-bit destination, 6-bit payload length) and a byte stream of payload.
- Serialises one bit per clock: start bit, header, payload, stop bit.
- Sits between the payload source/arbiter and the receiver's serial input.

---
 rtl/mssd_frame_tx.sv | 179 +++++++++++++++++
 tb/tb_mssd_frame_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mssd_frame_tx.sv
// mssd_frame_tx: single-wire frame serialiser (start, 2b dest, 6b len, payload MSB first, stop).
// Define MSSD_TX_GAP_EN to insert MIN_GAP idle-high cycles after every stop bit.
module mssd_frame_tx
`ifdef MSSD_TX_GAP_EN
   #(parameter int MIN_GAP = 4)
`endif
   (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_dest,
   input  logic [5:0] req_len,
   input  logic       pay_valid,
   output logic       pay_ready,
   input  logic [7:0] pay_data,
   output logic       ser_out,
   output logic       busy,
   output logic       done,
   output logic       err_len,
   output logic       err_underrun
);
   typedef enum logic [2:0] {
      IDLE, HDR, DATA, STOP
`ifdef MSSD_TX_GAP_EN
      , GAP
`endif
   } state_t;
   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [5:0] dcnt_q, dcnt_d;
   logic [7:0] hdr_q, hdr_d, sh_q, sh_d, hold_q, hold_d;
   logic [3:0] sh_n_q, sh_n_d, owed_q, owed_d;
   logic hold_v_q, hold_v_d, und_q, und_d;
   logic ser_out_q, ser_out_d, req_ready_q, req_ready_d, pay_ready_q, pay_ready_d;
   logic busy_q, busy_d, done_q, done_d, err_len_q, err_len_d, err_und_q, err_und_d;
`ifdef MSSD_TX_GAP_EN
   logic [3:0] gcnt_q, gcnt_d;
`endif
   logic acc, pay_fire, take, under;
   assign acc = req_valid & req_ready_q;
   assign pay_fire = pay_valid & pay_ready_q;
   assign take = (state_q == DATA) & (sh_n_q != 4'd0) & ~und_q;
   assign under = (state_q == DATA) & (sh_n_q == 4'd0) & ~und_q;
   // state_q names what is loaded into ser_out at the next edge, so the line trails it by one cycle
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      dcnt_d = dcnt_q;
      hdr_d = hdr_q;
      sh_d = take ? {sh_q[6:0], 1'b0} : sh_q;
      sh_n_d = sh_n_q - {3'd0, take};
      hold_d = hold_q;
      hold_v_d = hold_v_q;
      owed_d = owed_q;
      und_d = und_q | under;
      ser_out_d = 1'b1;
      done_d = 1'b0;
      err_len_d = 1'b0;
      err_und_d = under;
`ifdef MSSD_TX_GAP_EN
      gcnt_d = gcnt_q;
`endif
      if (sh_n_d == 4'd0 && hold_v_q) begin
         sh_d = hold_q;
         sh_n_d = 4'd8;
         hold_v_d = 1'b0;
      end
      if (pay_fire) begin
         owed_d = owed_q - 4'd1;
         if (!und_d && sh_n_d == 4'd0) begin
            sh_d = pay_data;
            sh_n_d = 4'd8;
         end else if (!und_d) begin
            hold_d = pay_data;
            hold_v_d = 1'b1;
         end
      end
      case (state_q)
         IDLE: begin
            if (acc && req_len == 6'd0) err_len_d = 1'b1;
            else if (acc) begin
               state_d = HDR;
               cnt_d = 3'd0;
               hdr_d = {req_dest, req_len};
               ser_out_d = 1'b0;
               sh_n_d = 4'd0;
               hold_v_d = 1'b0;
               und_d = 1'b0;
               owed_d = 4'((7'(req_len) + 7'd7) >> 3);
            end
         end
         HDR: begin
            ser_out_d = hdr_q[3'd7 - cnt_q];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DATA;
               dcnt_d = hdr_q[5:0];
            end
         end
         DATA: begin
            ser_out_d = take ? sh_q[7] : 1'b1;
            dcnt_d = dcnt_q - 6'd1;
            if (dcnt_q == 6'd1) state_d = STOP;
         end
         STOP: begin
            done_d = 1'b1;
`ifdef MSSD_TX_GAP_EN
            state_d = GAP;
            gcnt_d = 4'(MIN_GAP - 1);
`else
            state_d = IDLE;
`endif
         end
`ifdef MSSD_TX_GAP_EN
         GAP: begin
            state_d = gcnt_q == 4'd0 ? IDLE : GAP;
            gcnt_d = gcnt_q - 4'd1;
         end
`endif
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) | (state_q == STOP);
      req_ready_d = state_d == IDLE;
      pay_ready_d = (state_d == HDR || state_d == DATA) && !hold_v_d && owed_d != 4'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         dcnt_q <= '0;
         hdr_q <= '0;
         sh_q <= '0;
         sh_n_q <= '0;
         hold_q <= '0;
         hold_v_q <= 1'b0;
         owed_q <= '0;
         und_q <= 1'b0;
         ser_out_q <= 1'b1;
         req_ready_q <= 1'b0;
         pay_ready_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_len_q <= 1'b0;
         err_und_q <= 1'b0;
`ifdef MSSD_TX_GAP_EN
         gcnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         dcnt_q <= dcnt_d;
         hdr_q <= hdr_d;
         sh_q <= sh_d;
         sh_n_q <= sh_n_d;
         hold_q <= hold_d;
         hold_v_q <= hold_v_d;
         owed_q <= owed_d;
         und_q <= und_d;
         ser_out_q <= ser_out_d;
         req_ready_q <= req_ready_d;
         pay_ready_q <= pay_ready_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_len_q <= err_len_d;
         err_und_q <= err_und_d;
`ifdef MSSD_TX_GAP_EN
         gcnt_q <= gcnt_d;
`endif
      end
   end
   assign ser_out = ser_out_q;
   assign req_ready = req_ready_q;
   assign pay_ready = pay_ready_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err_len = err_len_q;
   assign err_underrun = err_und_q;
endmodule

// File: tb/tb_mssd_frame_tx.sv
// tb_mssd_frame_tx: directed frames with hand-computed line, pulse and handshake patterns.
module tb_mssd_frame_tx;
   logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, pay_valid = 1'b0;
   logic [1:0] req_dest = '0;
   logic [5:0] req_len = '0;
   logic [7:0] pay_data = '0;
   logic req_ready, pay_ready, ser_out, busy, done, err_len, err_underrun;
   int checks = 0, errors = 0;
   typedef struct {logic [7:0] d; int at;} beat_t;
   beat_t beats[$];
   logic [1:0] rd[2];
   logic [5:0] rl[2];
   int nreq, fires;
   logic [63:0] line, dn, un, bz, el;

   mssd_frame_tx dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_dest(req_dest), .req_len(req_len), .pay_valid(pay_valid), .pay_ready(pay_ready),
      .pay_data(pay_data), .ser_out(ser_out), .busy(busy), .done(done),
      .err_len(err_len), .err_underrun(err_underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic settle();
      req_valid = 1'b0;
      pay_valid = 1'b0;
      beats.delete();
      repeat (6) @(negedge clk);
   endtask

   // cycle 0 presents the first request; cycles 1..n are sampled into the shift masks
   task automatic run(input int n);
      int ri = 0;
      bit accp = 1'b0;
      line = '0; dn = '0; un = '0; bz = '0; el = '0; fires = 0;
      for (int c = 0; c <= n; c++) begin
         @(negedge clk);
         if (c > 0) begin
            line = {line[62:0], ser_out};
            dn = {dn[62:0], done};
            un = {un[62:0], err_underrun};
            bz = {bz[62:0], busy};
            el = {el[62:0], err_len};
         end
         if (accp) ri++;
         req_valid = ri < nreq;
         if (ri < nreq) begin
            req_dest = rd[ri];
            req_len = rl[ri];
         end
         accp = req_valid & req_ready;
         pay_valid = beats.size() > 0 && beats[0].at <= c;
         pay_data = pay_valid ? beats[0].d : 8'h00;
         if (pay_valid & pay_ready) begin
            fires++;
            void'(beats.pop_front());
         end
      end
   endtask

   initial begin
      @(negedge clk);
      chk("rst_ser", ser_out, 1);
      chk("rst_rdy", {req_ready, pay_ready}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {done, err_len, err_underrun}, 0);
      rst_n = 1'b1;
      settle();

      nreq = 1; rd[0] = 2'b10; rl[0] = 6'd5;
      beats.push_back('{8'hB4, 0}); beats.push_back('{8'h00, 0});
      run(16);
      chk("t1_line", line[15:0], {1'b0, 2'b10, 6'b000101, 5'b10110, 1'b1, 1'b1});
      chk("t1_done", dn[15:0], 16'h0002);
`ifdef MSSD_TX_GAP_EN
      chk("t1_busy", bz[15:0], 16'hFFFF);
`else
      chk("t1_busy", bz[15:0], 16'hFFFE);
`endif
      chk("t1_bytes", fires, 1);
      chk("t1_und", un[15:0], 0);
      settle();

      nreq = 1; rd[0] = 2'b00; rl[0] = 6'd16;
      beats.push_back('{8'hA5, 0}); beats.push_back('{8'h3C, 0});
      run(26);
      chk("t2_line", line[25:0], {1'b0, 2'b00, 6'b010000, 8'hA5, 8'h3C, 1'b1});
      chk("t2_und", un[25:0], 0);
      chk("t2_bytes", fires, 2);
      chk("t2_done", dn[25:0], 26'h1);
      settle();

      nreq = 1; rd[0] = 2'b01; rl[0] = 6'd12;
      beats.push_back('{8'hFF, 0}); beats.push_back('{8'hAA, 19});
      run(22);
      chk("t3_line", line[21:0], {1'b0, 2'b01, 6'b001100, 8'hFF, 4'hF, 1'b1});
      chk("t3_und", un[21:0], {17'b0, 1'b1, 4'b0});
      chk("t3_done", dn[21:0], 22'h1);
      chk("t3_bytes", fires, 2);
      settle();

      nreq = 1; rd[0] = 2'b11; rl[0] = 6'd0;
      run(3);
      chk("t4_line", line[2:0], 3'b111);
      chk("t4_errlen", el[2:0], 3'b100);
      chk("t4_busy", bz[2:0], 3'b000);
      settle();

      nreq = 2; rd[0] = 2'b01; rl[0] = 6'd1; rd[1] = 2'b10; rl[1] = 6'd2;
      beats.push_back('{8'h80, 0}); beats.push_back('{8'h40, 0});
`ifdef MSSD_TX_GAP_EN
      run(28);
      chk("t5_line", line[27:0], {11'b00100000111, 4'b1111, 12'b010000010011, 1'b1});
      chk("t5_done", dn[27:0], {10'b0, 1'b1, 15'b0, 1'b1, 1'b0});
`else
      run(24);
      chk("t5_line", line[23:0], {11'b00100000111, 12'b010000010011, 1'b1});
      chk("t5_done", dn[23:0], {10'b0, 1'b1, 11'b0, 1'b1, 1'b0});
`endif
      chk("t5_bytes", fires, 2);
      settle();

      nreq = 1; rd[0] = 2'b00; rl[0] = 6'd20;
      for (int i = 0; i < 3; i++) beats.push_back('{8'h00, 0});
      run(12);
      chk("t6_prebit", line[0], 0);
      chk("t6_prebusy", bz[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_ser", ser_out, 1);
      chk("t6_rst_busy", busy, 0);
      req_valid = 1'b0;
      pay_valid = 1'b0;
      beats.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      settle();
      nreq = 1; rd[0] = 2'b10; rl[0] = 6'd5;
      beats.push_back('{8'hB4, 0});
      run(16);
      chk("t6_line", line[15:0], {1'b0, 2'b10, 6'b000101, 5'b10110, 1'b1, 1'b1});
      chk("t6_bytes", fires, 1);
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
